alu_result_skid: RTL
====================

Name: alu_result_skid

Overview:
- Registered output stage directly downstream of the 8-way 32-bit result mux.
- Captures the selected result and its select code `ch`, and computes zero/negative flags.
- Presents the result to the writeback consumer over a valid/ready handshake.
- A 2-entry skid buffer gives full throughput with a fully registered `in_ready`, so consumer backpressure never creates a combinational path back to the mux/select logic.

Parameters:
- DATA_W, 32, width of the result datapath (matches mux width)
- CH_W, 3, width of the captured select code

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  mux output holds a result to accept this cycle
- in_ready  output  1  stage can accept; driven directly from a flop
- in_data  input  DATA_W  mux output
- in_ch  input  CH_W  select code that produced in_data
- out_valid  output  1  out/out_ch/flags hold a valid result
- out_ready  input  1  consumer accepts this cycle
- out  output  DATA_W  registered result
- out_ch  output  CH_W  registered select code
- out_zero  output  1  out == 0
- out_neg  output  1  out[DATA_W-1]

Behaviour:
- Reset (async assert, sync release):
  - out_valid=0, in_ready=1, out=0, out_ch=0, out_zero=1, out_neg=0.
  - Skid entry is emptied.
- Transfer rules:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - out/out_ch/flags hold stable while out_valid && !out_ready.
- Latency: an accepted input appears on `out` the next cycle when the buffer was empty.
- States (occupancy): EMPTY, ONE (main reg full), TWO (main + skid full).
  - EMPTY: accept → ONE.
  - ONE:
    - accept && !drain → TWO (input goes to skid).
    - accept && drain → ONE (input goes to main reg).
    - drain only → EMPTY.
  - TWO: in_ready=0, so no accept. Drain → ONE; skid moves to the main reg the same cycle.
- in_ready is registered: next value = !(next state == TWO).
- Simultaneous accept and drain in ONE: the new data replaces main and out_valid stays 1, giving zero-bubble throughput of 1/cycle.
- in_valid while in_ready=0: ignored; the producer must hold its data (mux inputs held).
- Flags:
  - Computed from the data entering the main reg and registered with it.
  - Never recomputed from `out` combinationally.
- Ordering: strict FIFO; data never lost or duplicated.
- Reset mid-operation: all entries are discarded immediately; in-flight data is lost by design.
- X-safety: in_data/in_ch are sampled only on an input transfer.

Optional Feature:
- Macro: ALU_RESULT_STALL_CNT_EN.
- Defined:
  - Adds output port stall_cnt [15:0].
  - Counts cycles with out_valid && !out_ready.
  - Saturates at 16'hFFFF; reset value 0.
  - Never wraps.
- Undefined: port and counter are absent. All other behaviour is identical.

Decomposition:
- Shared package alu_pkg:
  - DATA_W=32, CH_W=3.
  - Select-code constants CH_IN0..CH_IN7 (0..7).
  - Occupancy state typedef {EMPTY, ONE, TWO}.
- One natural sub-module, alu_result_flags: combinational zero/neg from a DATA_W word. It is instantiated once on the main-reg input path and reused by the ALU flag logic elsewhere.

Test Plan:
- Reset then idle: rst_n low mid-cycle → outputs go to reset values immediately (out_valid=0, in_ready=1, out_zero=1) without waiting for clk.
- Streaming with out_ready=1: feed in_ch=0..7 with in_data=1..8 on consecutive cycles → out sequence 1..8 one cycle later, out_ch 0..7, no bubbles, in_ready stays 1.
- Backpressure: out_ready=0, send 5 then 6 → state TWO, in_ready=0 the cycle after the second accept, out holds 5. A third value 7 presented meanwhile is not accepted. Raise out_ready → out 5, then 6, then 7, in order.
- Flags: send 0 → out_zero=1, out_neg=0. Send 32'h8000_0000 → out_zero=0, out_neg=1. Send 32'h7FFF_FFFF → both 0.
- Reset in TWO: fill with 9, 10, assert rst_n=0 → out_valid=0 and in_ready=1 at once. After release, the next accepted 11 is the first output.
- With ALU_RESULT_STALL_CNT_EN: hold out_valid=1, out_ready=0 for 70000 cycles → stall_cnt=16'hFFFF and stays there. Reset → 0.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU widths, select codes and skid occupancy states
package alu_pkg;
  localparam int DATA_W = 32;
  localparam int CH_W = 3;
  localparam logic [CH_W-1:0] CH_IN0 = 3'd0;
  localparam logic [CH_W-1:0] CH_IN1 = 3'd1;
  localparam logic [CH_W-1:0] CH_IN2 = 3'd2;
  localparam logic [CH_W-1:0] CH_IN3 = 3'd3;
  localparam logic [CH_W-1:0] CH_IN4 = 3'd4;
  localparam logic [CH_W-1:0] CH_IN5 = 3'd5;
  localparam logic [CH_W-1:0] CH_IN6 = 3'd6;
  localparam logic [CH_W-1:0] CH_IN7 = 3'd7;
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} occ_t;
endpackage

// File: rtl/alu_result_flags.sv
// alu_result_flags: combinational zero/negative flags of a W-bit word
//   i_data [W-1:0] in; o_zero = (i_data == 0); o_neg = i_data MSB
module alu_result_flags #(
  parameter int W = 32
) (
  input  logic [W-1:0] i_data,
  output logic         o_zero,
  output logic         o_neg
);
  assign o_zero = ~|i_data;
  assign o_neg = i_data[W-1];
endmodule

// File: rtl/alu_result_skid.sv
// alu_result_skid: registered result stage with 2-entry skid buffer and registered in_ready
//   in_valid/in_ready/in_data/in_ch: producer side (mux output + select code)
//   out_valid/out_ready/out/out_ch/out_zero/out_neg: writeback consumer side
//   ALU_RESULT_STALL_CNT_EN adds stall_cnt[15:0], saturating count of stalled output cycles
module alu_result_skid #(
  parameter int DATA_W = alu_pkg::DATA_W,
  parameter int CH_W = alu_pkg::CH_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CH_W-1:0]   in_ch,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out,
  output logic [CH_W-1:0]   out_ch,
  output logic              out_zero,
  output logic              out_neg
`ifdef ALU_RESULT_STALL_CNT_EN
  ,output logic [15:0]      stall_cnt
`endif
);
  import alu_pkg::occ_t;
  import alu_pkg::EMPTY;
  import alu_pkg::ONE;
  import alu_pkg::TWO;
  occ_t r_state, w_next;
  logic r_in_ready;
  logic [DATA_W-1:0] r_out, r_skid_data, w_src_data;
  logic [CH_W-1:0] r_out_ch, r_skid_ch, w_src_ch;
  logic r_zero, r_neg, w_zero, w_neg;
  logic w_acc, w_drain, w_load_main, w_load_skid;
  assign w_acc = in_valid && r_in_ready;
  assign w_drain = out_valid && out_ready;
  always_comb begin
    w_next = r_state;
    w_load_main = 1'b0;
    w_load_skid = 1'b0;
    case (r_state)
      EMPTY: begin
        w_next = w_acc ? ONE : EMPTY;
        w_load_main = w_acc;
      end
      ONE: begin
        w_next = (w_acc && !w_drain) ? TWO : (!w_acc && w_drain) ? EMPTY : ONE;
        w_load_main = w_acc && w_drain;
        w_load_skid = w_acc && !w_drain;
      end
      TWO: begin
        w_next = w_drain ? ONE : TWO;
        w_load_main = w_drain;
      end
      default: w_next = EMPTY;
    endcase
  end
  // In TWO the main reg refills from the skid entry; otherwise straight from the mux
  assign w_src_data = (r_state == TWO) ? r_skid_data : in_data;
  assign w_src_ch = (r_state == TWO) ? r_skid_ch : in_ch;
  alu_result_flags #(.W(DATA_W)) u_flags (
    .i_data(w_src_data),
    .o_zero(w_zero),
    .o_neg(w_neg)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_state <= w_next;
      r_in_ready <= (w_next != TWO);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out <= '0;
      r_out_ch <= '0;
      r_zero <= 1'b1;
      r_neg <= 1'b0;
      r_skid_data <= '0;
      r_skid_ch <= '0;
    end else begin
      if (w_load_main) begin
        r_out <= w_src_data;
        r_out_ch <= w_src_ch;
        r_zero <= w_zero;
        r_neg <= w_neg;
      end
      if (w_load_skid) begin
        r_skid_data <= in_data;
        r_skid_ch <= in_ch;
      end
    end
  end
  assign in_ready = r_in_ready;
  assign out_valid = (r_state != EMPTY);
  assign out = r_out;
  assign out_ch = r_out_ch;
  assign out_zero = r_zero;
  assign out_neg = r_neg;
`ifdef ALU_RESULT_STALL_CNT_EN
  logic [15:0] r_stall_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_stall_cnt <= '0;
    else if (out_valid && !out_ready && r_stall_cnt != 16'hFFFF) r_stall_cnt <= r_stall_cnt + 16'd1;
  end
  assign stall_cnt = r_stall_cnt;
`endif
endmodule
